// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus widths, reset level,
// the memory opcodes coming from ex_mem, and small decode helpers used by
// both the stage and its load-extension unit.
package mem_access_pkg;

  localparam int RegBus      = 32;
  localparam int RegAddrBus  = 5;
  localparam int AluOpBus    = 8;
  localparam int InstAddrBus = 32;

  localparam logic                  RstEnable  = 1'b1;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  typedef logic [AluOpBus-1:0] aluop_t;

  localparam aluop_t EX_LB  = 8'hE0;
  localparam aluop_t EX_LH  = 8'hE1;
  localparam aluop_t EX_LW  = 8'hE3;
  localparam aluop_t EX_LBU = 8'hE4;
  localparam aluop_t EX_LHU = 8'hE5;
  localparam aluop_t EX_SB  = 8'hE8;
  localparam aluop_t EX_SH  = 8'hE9;
  localparam aluop_t EX_SW  = 8'hEB;

  function automatic logic is_load(aluop_t op);
    return op inside {EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU};
  endfunction

  function automatic logic is_store(aluop_t op);
    return op inside {EX_SB, EX_SH, EX_SW};
  endfunction

  function automatic logic is_mem(aluop_t op);
    return is_load(op) || is_store(op);
  endfunction

  // Index of the final byte of the access (byte count minus one).
  function automatic logic [1:0] last_idx(aluop_t op);
    case (op)
      EX_LB, EX_LBU, EX_SB: return 2'd0;
      EX_LH, EX_LHU, EX_SH: return 2'd1;
      default:              return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Load result extension. Maps the assembled little-endian load buffer to the
// 32-bit write-back value: sign-extend for LB/LH, zero-extend for LBU/LHU,
// pass through for LW.
//   op   : latched load opcode
//   data : assembled byte buffer (unused upper bytes are zero)
//   ext  : extended result
module load_ext
  import mem_access_pkg::*;
(
  input  aluop_t            op,
  input  logic [RegBus-1:0] data,
  output logic [RegBus-1:0] ext
);

  always_comb begin
    ext = data;
    case (op)
      EX_LB:   ext = {{24{data[7]}}, data[7:0]};
      EX_LBU:  ext = {24'b0, data[7:0]};
      EX_LH:   ext = {{16{data[15]}}, data[15:0]};
      EX_LHU:  ext = {16'b0, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Serialises byte/half/word loads and stores
// into little-endian single-byte transactions on an 8-bit memory port and
// holds the pipeline via stall_req_o while a transfer is in flight.
// Non-memory operations pass straight through to mem_wb.
//   clk, rst           : clock, synchronous active-high reset
//   aluop_i ... wdata_i: instruction from ex_mem
//   mem_*              : byte-wide memory controller handshake
//   wd_o/wreg_o/wdata_o: write-back to mem_wb
//   stall_req_o        : hold ex_mem and upstream
module mem_access
  import mem_access_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  aluop_t                aluop_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [RegBus-1:0]     store_data_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     wdata_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [7:0]            mem_data_o,
  input  logic                  mem_ack_i,
  input  logic [7:0]            mem_data_i,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  stall_req_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]            state;
  aluop_t                op_q;
  logic [31:0]           base_q;
  logic [RegBus-1:0]     sdata_q;
  logic [RegAddrBus-1:0] wd_q;
  logic [1:0]            idx_q;
  logic [RegBus-1:0]     buf_q;
  logic [RegBus-1:0]     ext_data;

  load_ext u_load_ext (
    .op   (op_q),
    .data (buf_q),
    .ext  (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state   <= S_IDLE;
      op_q    <= '0;
      base_q  <= '0;
      sdata_q <= '0;
      wd_q    <= NOPRegAddr;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mem(aluop_i)) begin
            op_q    <= aluop_i;
            base_q  <= mem_addr_i;
            sdata_q <= store_data_i;
            wd_q    <= wd_i;
            idx_q   <= '0;
            buf_q   <= '0;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Without an ack nothing moves, so the request is held as-is.
          if (mem_ack_i) begin
            if (is_load(op_q)) buf_q[{idx_q, 3'b000} +: 8] <= mem_data_i;
            idx_q <= idx_q + 2'd1;
            if (idx_q == last_idx(op_q)) state <= S_DONE;
          end
        end
        // Inputs still show the finished instruction here; ignore them.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    stall_req_o = 1'b0;
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    case (state)
      S_IDLE: begin
        if (is_mem(aluop_i)) begin
          stall_req_o = 1'b1;
          wreg_o      = 1'b0;
          wdata_o     = ZeroWord;
        end
      end
      S_ACCESS: begin
        mem_req_o   = 1'b1;
        mem_we_o    = is_store(op_q);
        mem_addr_o  = base_q + {30'b0, idx_q};  // wraps past 0xFFFFFFFF
        mem_data_o  = sdata_q[{idx_q, 3'b000} +: 8];
        stall_req_o = 1'b1;
        wd_o        = wd_q;
        wreg_o      = 1'b0;
        wdata_o     = ZeroWord;
      end
      S_DONE: begin
        wd_o    = wd_q;
        wreg_o  = is_load(op_q);
        wdata_o = is_load(op_q) ? ext_data : ZeroWord;
      end
      default: ;
    endcase
    // Reset suppresses any write-back, including from an abandoned access.
    if (rst == RstEnable) begin
      wd_o    = NOPRegAddr;
      wreg_o  = 1'b0;
      wdata_o = ZeroWord;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import mem_access_pkg::*;

  localparam aluop_t OP_NOP = 8'h00;
  localparam aluop_t OP_OR  = 8'h25;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  aluop_t      aluop_i;
  logic [31:0] mem_addr_i, store_data_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_o, mem_data_i;
  logic [4:0]  wd_o;
  logic        wreg_o, stall_req_o;
  logic [31:0] wdata_o;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .store_data_i(store_data_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o)
  );

  typedef struct { logic we; logic [31:0] addr; logic [7:0] data; } txn_t;
  typedef struct { logic wreg; logic [4:0] wd; logic [31:0] wdata; logic chk_wd; } wb_t;

  txn_t        exp_txn[$];
  wb_t         exp_wb[$];
  logic [7:0]  mem [logic [31:0]];
  int          n_cmp = 0, n_bad = 0;
  int          hold_acks = 0;
  logic        noise = 1'b0;
  logic        post_rst_chk = 1'b0;
  logic [31:0] last_wdata = '0;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string msg);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", msg);
  endtask

  // Reference: what a load must return given the bytes in memory.
  function automatic logic [31:0] model_load(input aluop_t op, input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = (op == EX_LB || op == EX_LBU) ? 1 : (op == EX_LH || op == EX_LHU) ? 2 : 4;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_rd(addr + 32'(i))) << (8 * i));
    if (op == EX_LB && v >= 32'h80)   v = v | 32'hFFFF_FF00;
    if (op == EX_LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // Memory responder followed by the single compare process.
  always @(negedge clk) begin
    if (mem_req_o) begin
      if (hold_acks > 0) begin
        mem_ack_i = 1'b0;
        hold_acks--;
      end else begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_rd(mem_addr_o);
      end
    end else begin
      noise      = ~noise;      // stray acks with no request must be ignored
      mem_ack_i  = noise;
      mem_data_i = 8'hEE;
    end
    #1;
    if (rst) begin
      chk("rst_wreg", 32'(wreg_o), 32'd0);
      chk("rst_wd", 32'(wd_o), 32'd0);
      chk("rst_wdata", wdata_o, 32'd0);
    end else begin
      if (post_rst_chk) begin
        chk("post_rst_req", 32'(mem_req_o), 32'd0);
        chk("post_rst_we", 32'(mem_we_o), 32'd0);
        chk("post_rst_addr", mem_addr_o, 32'd0);
        chk("post_rst_data", 32'(mem_data_o), 32'd0);
        chk("post_rst_stall", 32'(stall_req_o), 32'd0);
        post_rst_chk = 1'b0;
      end
      if (stall_req_o) begin
        chk("stall_wreg", 32'(wreg_o), 32'd0);
      end else begin
        chk("nostall_req", 32'(mem_req_o), 32'd0);
        if (exp_wb.size() == 0) fail_now("wb_extra: write-back slot with nothing outstanding");
        else begin
          wb_t w;
          w = exp_wb.pop_front();
          chk("wb_wreg", 32'(wreg_o), 32'(w.wreg));
          chk("wb_wdata", wdata_o, w.wdata);
          if (w.chk_wd) chk("wb_wd", 32'(wd_o), 32'(w.wd));
          last_wdata = wdata_o;
        end
      end
      if (mem_req_o) begin
        if (exp_txn.size() == 0) fail_now("txn_extra: memory request with nothing outstanding");
        else begin
          chk("txn_we", 32'(mem_we_o), 32'(exp_txn[0].we));
          chk("txn_addr", mem_addr_o, exp_txn[0].addr);
          if (exp_txn[0].we) chk("txn_data", 32'(mem_data_o), 32'(exp_txn[0].data));
          if (mem_ack_i) void'(exp_txn.pop_front());
        end
      end
    end
    if (mem_req_o && mem_ack_i && mem_we_o) mem[mem_addr_o] = mem_data_o;
  end

  // Presents one instruction (called just after a rising edge) and holds it
  // until the stage stops stalling; returns just after the next rising edge.
  task automatic run_op(input aluop_t op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        output int cycles, output int stalls, output int first_req);
    int n;
    logic done;
    aluop_i = op; mem_addr_i = addr; store_data_i = sdata;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    if (is_mem(op)) begin
      n = (op inside {EX_LB, EX_LBU, EX_SB}) ? 1 : (op inside {EX_LH, EX_LHU, EX_SH}) ? 2 : 4;
      for (int i = 0; i < n; i++)
        exp_txn.push_back('{is_store(op), addr + 32'(i), 8'(sdata >> (8 * i))});
      if (is_store(op)) exp_wb.push_back('{1'b0, wd, 32'd0, 1'b0});
      else              exp_wb.push_back('{1'b1, wd, model_load(op, addr), 1'b1});
    end else begin
      exp_wb.push_back('{wreg, wd, wdata, 1'b1});
    end
    cycles = 0; stalls = 0; first_req = -1; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk); #2;
      cycles++;
      if (mem_req_o && first_req < 0) first_req = k;
      if (stall_req_o) stalls++;
      else done = 1'b1;
    end
    if (!done) fail_now("timeout: stall_req_o never dropped");
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c, s, f;
    aluop_i = OP_NOP; mem_addr_i = 0; store_data_i = 0;
    wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    mem_ack_i = 1'b0; mem_data_i = 8'h00;
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    mem[32'h20]  = 8'h80;
    mem[32'h40]  = 8'h00; mem[32'h41] = 8'h80;
    mem[32'h200] = 8'hA1; mem[32'h201] = 8'hA2;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    post_rst_chk = 1'b1;

    run_op(OP_NOP, 0, 0, 5'd5, 1'b1, 32'h1234, c, s, f);
    chk("nop_cycles", 32'(c), 32'd1);
    chk("nop_stalls", 32'(s), 32'd0);
    chk("nop_wdata_lit", last_wdata, 32'h1234);
    run_op(OP_OR, 32'h104, 0, 5'd3, 1'b0, 32'hCAFE, c, s, f);

    run_op(EX_LW, 32'h100, 0, 5'd4, 1'b1, 32'h0, c, s, f);
    chk("lw_cycles", 32'(c), 32'd6);
    chk("lw_stalls", 32'(s), 32'd5);
    chk("lw_first_req", 32'(f), 32'd1);
    chk("lw_lit", last_wdata, 32'h1234_5678);

    run_op(EX_LB, 32'h20, 0, 5'd6, 1'b1, 32'h0, c, s, f);
    chk("lb_cycles", 32'(c), 32'd3);
    chk("lb_lit", last_wdata, 32'hFFFF_FF80);
    run_op(EX_LBU, 32'h20, 0, 5'd6, 1'b1, 32'h0, c, s, f);
    chk("lbu_lit", last_wdata, 32'h0000_0080);
    run_op(EX_LH, 32'h40, 0, 5'd7, 1'b1, 32'h0, c, s, f);
    chk("lh_cycles", 32'(c), 32'd4);
    chk("lh_lit", last_wdata, 32'hFFFF_8000);
    run_op(EX_LHU, 32'h40, 0, 5'd7, 1'b1, 32'h0, c, s, f);
    chk("lhu_lit", last_wdata, 32'h0000_8000);

    hold_acks = 2;
    run_op(EX_SH, 32'hFFFF_FFFF, 32'hAABB_CCDD, 5'd8, 1'b1, 32'h0, c, s, f);
    chk("sh_cycles", 32'(c), 32'd6);
    chk("sh_stalls", 32'(s), 32'd5);
    chk("sh_first_req", 32'(f), 32'd1);
    chk("sh_byte_top", 32'(mem_rd(32'hFFFF_FFFF)), 32'h0000_00DD);
    chk("sh_byte_wrap", 32'(mem_rd(32'h0)), 32'h0000_00CC);
    chk("sh_wdata_lit", last_wdata, 32'h0);

    run_op(EX_SW, 32'h300, 32'h1122_3344, 5'd10, 1'b1, 32'h0, c, s, f);
    chk("sw_cycles", 32'(c), 32'd6);
    run_op(EX_LB, 32'h302, 0, 5'd11, 1'b1, 32'h0, c, s, f);
    chk("sw_lb_first_req", 32'(f), 32'd1);
    chk("sw_lb_cycles", 32'(c), 32'd3);
    chk("sw_lb_lit", last_wdata, 32'h0000_0022);

    // Reset in the middle of a word load, after its first byte.
    aluop_i = EX_LW; mem_addr_i = 32'h200; wd_i = 5'd7; wreg_i = 1'b1;
    exp_txn.push_back('{1'b0, 32'h200, 8'h00});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    aluop_i = OP_NOP; wreg_i = 1'b0; wd_i = 5'd2; wdata_i = 32'h5555;
    @(posedge clk); #1;
    rst = 1'b0;
    post_rst_chk = 1'b1;
    run_op(OP_NOP, 0, 0, 5'd2, 1'b0, 32'h5555, c, s, f);
    chk("rst_abort_cycles", 32'(c), 32'd1);
    chk("rst_abort_stalls", 32'(s), 32'd0);
    repeat (2) run_op(OP_NOP, 0, 0, 5'd2, 1'b0, 32'h5555, c, s, f);

    chk("txn_left", 32'(exp_txn.size()), 32'd0);
    chk("wb_left", 32'(exp_wb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
